// File: rtl/secuenciador_suma_if.sv
// Button/digit inputs and command-strobe outputs of the calculator sequencer.
// The sequencer (slave) receives raw buttons and drives single-cycle strobes to the datapath.
interface secuenciador_suma_if;
  logic       push;
  logic       guardar;
  logic       finalizar;
  logic [3:0] entrada;
  logic       digit_we;
  logic [1:0] digit_idx;
  logic [3:0] digit_val;
  logic       clr_num;
  logic       save_op;
  logic       sum_go;
  logic       show_result;
  logic       digit_err;
  logic [1:0] state_dbg;

  modport master (
    output push, guardar, finalizar, entrada,
    input  digit_we, digit_idx, digit_val, clr_num, save_op, sum_go,
    input  show_result, digit_err, state_dbg
  );

  modport slave (
    input  push, guardar, finalizar, entrada,
    output digit_we, digit_idx, digit_val, clr_num, save_op, sum_go,
    output show_result, digit_err, state_dbg
  );
endinterface

// File: rtl/secuenciador_suma.sv
// Control FSM for the digit-entry / save / sum calculator datapath.
// Optional button debounce is enabled by defining SECUENCIADOR_DEBOUNCE_EN.
module secuenciador_suma #(
  parameter int MAX_DIGITS = 4,
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  secuenciador_suma_if.slave bus
);

  // Handshake: strobes (digit_we, clr_num, save_op, sum_go) are single-cycle
  // commands with no ready/backpressure; the datapath must act on them in that cycle.

  typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_RES = 2'd2} state_t;

  if (MAX_DIGITS < 1 || MAX_DIGITS > 4) begin : g_chk_max
    $error("MAX_DIGITS must be 1..4");
  end
  if (DEB_CYCLES < 2) begin : g_chk_deb
    $error("DEB_CYCLES must be >= 2");
  end

  // Buttons packed as {finalizar, guardar, push}
  logic [2:0] raw, sync1, sync2, lvl, lvl_d, ev_q;
  assign raw = {bus.finalizar, bus.guardar, bus.push};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl_d <= '0;
      ev_q  <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      lvl_d <= lvl;
      ev_q  <= lvl & ~lvl_d;
    end
  end

`ifdef SECUENCIADOR_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES);
  logic [DW-1:0] deb_cnt [3];
  logic [2:0]    deb_lvl;

  // Level follows the synchronized input only after DEB_CYCLES differing samples in a row
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_lvl <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          deb_lvl[i] <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end
  assign lvl = deb_lvl;
`else
  assign lvl = sync2;
`endif

  logic ev_fin, ev_gua, ev_push, ev_any;
  assign ev_fin  = ev_q[2];
  assign ev_gua  = ev_q[1] & ~ev_q[2];
  assign ev_push = ev_q[0] & ~ev_q[1] & ~ev_q[2];
  assign ev_any  = |ev_q;

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic       we_q, save_q, sum_q, clr_q, show_q, err_q;
  logic       we_n, save_n, sum_n, clr_n, err_n;
  logic [1:0] idx_q, idx_n;
  logic [3:0] val_q, val_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    we_n    = 1'b0;
    save_n  = 1'b0;
    sum_n   = 1'b0;
    clr_n   = 1'b0;
    idx_n   = idx_q;
    val_n   = val_q;
    err_n   = err_q;
    case (state)
      S_A, S_B: begin
        if (ev_fin) begin
          if (state == S_B && cnt != 3'd0) begin
            sum_n   = 1'b1;
            state_n = S_RES;
          end
        end else if (ev_gua) begin
          if (state == S_A && cnt != 3'd0) begin
            save_n  = 1'b1;
            clr_n   = 1'b1;
            cnt_n   = 3'd0;
            state_n = S_B;
          end
        end else if (ev_push) begin
          if (bus.entrada <= 4'd9 && cnt < 3'(MAX_DIGITS)) begin
            we_n  = 1'b1;
            idx_n = cnt[1:0];
            val_n = bus.entrada;
            cnt_n = cnt + 3'd1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_RES: begin
        // Any button leaves the result view; a push here is consumed
        if (ev_any) begin
          clr_n   = 1'b1;
          cnt_n   = 3'd0;
          state_n = S_A;
        end
      end
      default: state_n = S_A;
    endcase
    if (clr_n) err_n = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_A;
      cnt    <= '0;
      we_q   <= 1'b0;
      save_q <= 1'b0;
      sum_q  <= 1'b0;
      clr_q  <= 1'b0;
      show_q <= 1'b0;
      err_q  <= 1'b0;
      idx_q  <= '0;
      val_q  <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      we_q   <= we_n;
      save_q <= save_n;
      sum_q  <= sum_n;
      clr_q  <= clr_n;
      show_q <= (state_n == S_RES);
      err_q  <= err_n;
      idx_q  <= idx_n;
      val_q  <= val_n;
    end
  end

  assign bus.digit_we    = we_q;
  assign bus.digit_idx   = idx_q;
  assign bus.digit_val   = val_q;
  assign bus.clr_num     = clr_q;
  assign bus.save_op     = save_q;
  assign bus.sum_go      = sum_q;
  assign bus.show_result = show_q;
  assign bus.digit_err   = err_q;
  assign bus.state_dbg   = state;

endmodule

// File: doc/secuenciador_suma.md
# secuenciador_suma

Control FSM for the digit-entry / save / sum calculator datapath. It conditions the raw `push`, `guardar` and `finalizar` buttons and validates each BCD digit on `entrada`. It then issues single-cycle command strobes that sequence operand entry, operand save, sum and result display, and it tracks the digit count and display mode. It sits between the board buttons and the entry, save, sum and display-mux blocks, and replaces their direct button connections.

## Interface
- `MAX_DIGITS`, default 4: digits per operand, 1..4.
- `DEB_CYCLES`, default 16: stable-sample count for debounce, ≥2; used only with `SECUENCIADOR_DEBOUNCE_EN`.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `push` in 1: raw button level; a rising edge enters a digit.
- `guardar` in 1: raw button level; a rising edge saves operand A.
- `finalizar` in 1: raw button level; a rising edge computes the sum.
- `entrada` in 4: digit value, sampled in the cycle the internal push edge is detected.
- `digit_we` out 1: one-cycle pulse that writes `digit_val` at `digit_idx`.
- `digit_idx` out 2: target digit position, 0 = least significant.
- `digit_val` out 4: registered copy of `entrada`.
- `clr_num` out 1: one-cycle pulse that clears the entry register.
- `save_op` out 1: one-cycle pulse that latches the current number as operand A.
- `sum_go` out 1: one-cycle pulse that starts the sum of operand A and the current number.
- `show_result` out 1: level; 1 selects the result on the display mux.
- `digit_err` out 1: sticky flag for a rejected digit (value > 9, or operand full).

## Operation
- Input conditioning per button:
  - 2-FF synchronizer, then rising-edge detector producing a 1-cycle internal event.
- Event priority when several events occur in the same cycle: `finalizar` > `guardar` > `push`. Lower-priority events in that cycle are dropped, not queued.
- FSM states: `S_A` (entering operand A), `S_B` (entering operand B), `S_RES` (showing result). Reset state is `S_A`.
- Digit accept, valid in `S_A` or `S_B`:
  - Condition: `entrada` ≤ 9 and `cnt` < `MAX_DIGITS`.
  - Action: `digit_we`=1, `digit_idx`=`cnt`, `digit_val`=`entrada`, then `cnt`++.
  - Otherwise: no write, and `digit_err` is set. `digit_err` clears only on `clr_num` or reset.
- `S_A` + `guardar` event:
  - `cnt`>0: `save_op`=1 and `clr_num`=1 in the same cycle, `cnt`←0, go to `S_B`.
  - `cnt`=0: ignored.
- `S_A` + `finalizar` event: ignored; no operand has been saved.
- `S_B` + `finalizar` event:
  - `cnt`>0: `sum_go`=1, go to `S_RES`.
  - `cnt`=0: ignored.
- `S_B` + `guardar` event: ignored.
- `S_RES`:
  - `show_result`=1.
  - Any event (push, guardar or finalizar): `clr_num`=1, `cnt`←0, go to `S_A`. The triggering push is consumed and does not write a digit.
- `show_result` is 0 in `S_A` and `S_B`.
- At most one of `digit_we`, `save_op`, `sum_go` is high in any cycle.

## Timing
- Reset (async assert, sync deassert):
  - All strobes 0, `digit_idx`=0, `digit_val`=0, `show_result`=0, `digit_err`=0, `cnt`=0, state `S_A`.
  - Synchronizer and debounce state are cleared.
- All outputs are registered.
- Latency, raw rising edge (first cycle the level is sampled high) to strobe:
  - 3 cycles without debounce.
  - 3+`DEB_CYCLES` cycles with debounce.
- Button held high: exactly one event. A new event requires a low level first; with debounce, the low must persist for `DEB_CYCLES` samples.
- Back-to-back events on consecutive cycles are each processed, since the FSM accepts one event per cycle.
- Reset asserted mid-operation: strobes drop immediately. The downstream datapath is expected to be reset by the same `rst`.

## Configuration
- `SECUENCIADOR_DEBOUNCE_EN` defined:
  - Each synchronized button feeds a debounce counter.
  - The debounced level changes only after `DEB_CYCLES` consecutive equal samples.
  - The edge detector runs on the debounced level.
- `SECUENCIADOR_DEBOUNCE_EN` undefined:
  - The edge detector runs directly on the synchronizer output.
  - `DEB_CYCLES` is unused and no counter logic is generated.

## Test plan
- Reset, then push `entrada`=3, 7: `digit_we` pulses with idx 0 then 1, `digit_val` 3 then 7, 3 cycles after each edge; `show_result`=0.
- Enter 5, `guardar`, enter 2, `finalizar`: `save_op`+`clr_num` in one cycle; `sum_go` on the later event; `show_result`=1. Next push gives `clr_num`=1, `show_result`=0, no `digit_we`.
- With `MAX_DIGITS`=4, push 5 digits: 4 writes (idx 0..3); the 5th gives no write and `digit_err`=1. Push `entrada`=0xA in a fresh operand: no write, `digit_err`=1.
- `guardar` with `cnt`=0, and `finalizar` in `S_A`: no strobes, state unchanged. Raise `guardar` and `push` in the same cycle in `S_A` with `cnt`=1: only `save_op`/`clr_num`, no `digit_we`.
- With `SECUENCIADOR_DEBOUNCE_EN` and `DEB_CYCLES`=16, a `push` glitch high for 5 cycles: no strobe. Held 40 cycles: exactly one `digit_we`, 19 cycles after the edge.
- Drop `rst` low in `S_B` with a `sum_go` pending edge in the synchronizer: all outputs 0 immediately. After release, the state is `S_A` and no stale event fires.
